fft_sram_responder: RTL

- Memory-side responder for the fft_top SRAM interface: a 256 x 128 bank that serves fft_top's two read ports (1-cycle registered latency) and two write ports.
- Adds a host load/unload port and a run-control FSM, which drives fft_top's i_working and hands the bank to the FFT for the duration of a transform.
- Sits between the host bus adapter and fft_top.

---
 rtl/fft_sram_responder.sv | 95 +++++++++
 1 files changed

// File: rtl/fft_sram_responder.sv
// fft_sram_responder: 256x128 SRAM bank serving fft_top read/write ports, a host load/unload port and run control.
// Define FFT_SRAM_BYPASS_EN for write-first forwarding on the FFT read ports (read-first otherwise).
module fft_sram_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 128,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_host_valid,
  output logic              o_host_ready,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_host_rvalid,
  output logic [DATA_W-1:0] o_host_rdata,
  input  logic              i_start,
  output logic              o_working,
  output logic              o_done,
  input  logic              i_fft_done,
  input  logic [ADDR_W-1:0] i_raddress1,
  input  logic [ADDR_W-1:0] i_raddress2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2,
  input  logic [ADDR_W-1:0] i_waddress1,
  input  logic [ADDR_W-1:0] i_waddress2,
  input  logic [DATA_W-1:0] i_wdata1,
  input  logic [DATA_W-1:0] i_wdata2,
  input  logic              i_global_write_enable,
  output logic [15:0]       o_wr_count,
  output logic              o_collision
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
  state_t state, next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic host_fire, host_rd, fft_we, run_entry;
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < LIMIT;
  endfunction
  function automatic logic [DATA_W-1:0] rd_mem(input logic [ADDR_W-1:0] a);
    return in_range(a) ? mem[a] : '0;
  endfunction
  function automatic logic [DATA_W-1:0] fft_rd(input logic [ADDR_W-1:0] a);
`ifdef FFT_SRAM_BYPASS_EN
    return (in_range(a) && fft_we && a == i_waddress2) ? i_wdata2 :
           (in_range(a) && fft_we && a == i_waddress1) ? i_wdata1 : rd_mem(a);
`else
    return rd_mem(a);
`endif
  endfunction
  always_comb begin
    next = state == IDLE ? (i_start ? RUN : IDLE) :
           state == RUN  ? (i_fft_done ? DONE : RUN) : IDLE;
    o_working    = state == RUN;
    o_done       = state == DONE;
    o_host_ready = state == IDLE && !rst;
    host_fire    = i_host_valid && o_host_ready;
    host_rd      = host_fire && !i_host_we;
    fft_we       = i_global_write_enable && state == RUN;
    run_entry    = state == IDLE && i_start;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= next;
  // Host and FFT writes are exclusive by state; port 2 is written last so it wins a collision.
  always_ff @(posedge clk) begin
    if (host_fire && i_host_we && in_range(i_host_addr)) mem[i_host_addr] <= i_host_wdata;
    if (fft_we && in_range(i_waddress1)) mem[i_waddress1] <= i_wdata1;
    if (fft_we && in_range(i_waddress2)) mem[i_waddress2] <= i_wdata2;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      o_host_rvalid <= 1'b0;
      o_host_rdata  <= '0;
      o_rdata1      <= '0;
      o_rdata2      <= '0;
      o_collision   <= 1'b0;
      o_wr_count    <= '0;
    end else begin
      o_host_rvalid <= host_rd;
      if (host_rd) o_host_rdata <= rd_mem(i_host_addr);
      if (state == RUN) begin
        o_rdata1 <= fft_rd(i_raddress1);
        o_rdata2 <= fft_rd(i_raddress2);
      end
      if (run_entry) begin
        o_collision <= 1'b0;
        o_wr_count  <= '0;
      end else if (fft_we) begin
        if (i_waddress1 == i_waddress2) o_collision <= 1'b1;
        if (o_wr_count != 16'hFFFF) o_wr_count <= o_wr_count + 16'd1;
      end
    end
endmodule
